// File: rtl/ctrl_data_rx.sv
// Receiving sink for the ctrl/data valid-ready stream: DEPTH-entry FIFO decoupling,
// packet counting on delivered LAST beats, and a sticky upstream protocol checker.
module ctrl_data_rx #(
  parameter int CTRL_BITS = 8,
  parameter int DATA_BITS = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_BITS  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CTRL_BITS-1:0]       s__ctrl,
  input  logic [DATA_BITS-1:0]       s__data,
  input  logic                       s__valid,
  output logic                       s__ready,
  output logic [CTRL_BITS-1:0]       m__ctrl,
  output logic [DATA_BITS-1:0]       m__data,
  output logic                       m__valid,
  input  logic                       m__ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_BITS-1:0]        pkt_cnt,
  output logic                       proto_err,
  input  logic                       clr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic {ST_IDLE, ST_STALL} state_t;

  logic [CTRL_BITS-1:0] mem_ctrl [DEPTH];
  logic [DATA_BITS-1:0] mem_data [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;

  state_t               state_q;
  state_t               state_d;
  logic                 capture;
  logic                 err_set;
  logic [CTRL_BITS-1:0] held_ctrl;
  logic [DATA_BITS-1:0] held_data;

  // Ready/valid derive only from registered occupancy, so there is no s__ -> m__
  // or m__ready -> s__ready combinational path.
  assign s__ready = (level != FULL_LVL);
  assign m__valid = (level != '0);
  assign push     = s__valid & s__ready;
  assign pop      = m__valid & m__ready;
  assign m__ctrl  = mem_ctrl[rd_ptr];
  assign m__data  = mem_data[rd_ptr];

  // ---- storage write stage (data path, not reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ctrl[wr_ptr] <= s__ctrl;
      mem_data[wr_ptr] <= s__data;
    end
    if (capture) begin
      held_ctrl <= s__ctrl;
      held_data <= s__data;
    end
  end

  // ---- control state: pointers, occupancy, counters ----
  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_cnt   <= '0;
      state_q   <= ST_IDLE;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (pop && m__ctrl[0]) pkt_cnt <= pkt_cnt + 1'b1;
      state_q <= state_d;
      if (err_set)      proto_err <= 1'b1;
      else if (clr_err) proto_err <= 1'b0;
    end
  end

  // A stalled beat must stay valid and stable until it is accepted.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s__valid && !s__ready) begin
          state_d = ST_STALL;
          capture = 1'b1;
        end
      end
      ST_STALL: begin
        if (!s__valid || (s__ctrl != held_ctrl) || (s__data != held_data)) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else if (s__ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_data_rx.sv
// Directed bench for ctrl_data_rx: vector table for fill/drain/backpressure plus
// hand sequences for streaming, protocol errors, async reset and counter wrap.
module tb_ctrl_data_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_ctrl;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_ctrl;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  level;
  logic [15:0] pkt_cnt;
  logic        proto_err;
  logic        clr_err;

  // Second instance with a narrow counter for the wrap check
  logic [7:0]  w_ctrl;
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_sready;
  logic [7:0]  w_mctrl;
  logic [31:0] w_mdata;
  logic        w_mvalid;
  logic        w_mready;
  logic [2:0]  w_level;
  logic [3:0]  w_pkt;
  logic        w_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_data_rx dut (
    .clk(clk), .rst_n(rst_n),
    .s__ctrl(s_ctrl), .s__data(s_data), .s__valid(s_valid), .s__ready(s_ready),
    .m__ctrl(m_ctrl), .m__data(m_data), .m__valid(m_valid), .m__ready(m_ready),
    .level(level), .pkt_cnt(pkt_cnt), .proto_err(proto_err), .clr_err(clr_err)
  );

  ctrl_data_rx #(.CNT_BITS(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .s__ctrl(w_ctrl), .s__data(w_data), .s__valid(w_valid), .s__ready(w_sready),
    .m__ctrl(w_mctrl), .m__data(w_mdata), .m__valid(w_mvalid), .m__ready(w_mready),
    .level(w_level), .pkt_cnt(w_pkt), .proto_err(w_err), .clr_err(1'b0)
  );

  typedef struct {
    logic        sv;
    logic [7:0]  sc;
    logic [31:0] sd;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic [31:0] e_md;
    logic [2:0]  e_lvl;
    logic [15:0] e_pkt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic sv, logic [7:0] sc, logic [31:0] sd, logic mr,
                              logic e_sr, logic e_mv, logic [31:0] e_md,
                              logic [2:0] e_lvl, logic [15:0] e_pkt);
    vec_t v;
    v.sv = sv; v.sc = sc; v.sd = sd; v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_lvl = e_lvl; v.e_pkt = e_pkt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [7:0] sc, input logic [31:0] sd,
                       input logic mr, input logic clr);
    s_valid = sv; s_ctrl = sc; s_data = sd; m_ready = mr; clr_err = clr;
  endtask

  initial begin
    // inputs: sv sc sd mr | expected: s_ready m_valid m_data level pkt_cnt
    vecs[0]  = mk(1, 8'h00, 1,  0,  1, 0, 0,  0, 0);
    vecs[1]  = mk(1, 8'h00, 2,  0,  1, 1, 1,  1, 0);
    vecs[2]  = mk(1, 8'h01, 3,  0,  1, 1, 1,  2, 0);
    vecs[3]  = mk(0, 8'h00, 0,  0,  1, 1, 1,  3, 0);
    vecs[4]  = mk(0, 8'h00, 0,  1,  1, 1, 1,  3, 0);
    vecs[5]  = mk(0, 8'h00, 0,  1,  1, 1, 2,  2, 0);
    vecs[6]  = mk(0, 8'h00, 0,  1,  1, 1, 3,  1, 0);
    vecs[7]  = mk(0, 8'h00, 0,  0,  1, 0, 0,  0, 1);
    vecs[8]  = mk(1, 8'h00, 10, 0,  1, 0, 0,  0, 1);
    vecs[9]  = mk(1, 8'h00, 11, 0,  1, 1, 10, 1, 1);
    vecs[10] = mk(1, 8'h00, 12, 0,  1, 1, 10, 2, 1);
    vecs[11] = mk(1, 8'h00, 13, 0,  1, 1, 10, 3, 1);
    vecs[12] = mk(1, 8'h00, 14, 0,  0, 1, 10, 4, 1);
    vecs[13] = mk(1, 8'h00, 14, 1,  0, 1, 10, 4, 1);
    vecs[14] = mk(1, 8'h00, 14, 0,  1, 1, 11, 3, 1);
    vecs[15] = mk(0, 8'h00, 0,  1,  0, 1, 11, 4, 1);
    vecs[16] = mk(0, 8'h00, 0,  1,  1, 1, 12, 3, 1);
    vecs[17] = mk(0, 8'h00, 0,  1,  1, 1, 13, 2, 1);
    vecs[18] = mk(0, 8'h00, 0,  1,  1, 1, 14, 1, 1);
    vecs[19] = mk(0, 8'h00, 0,  0,  1, 0, 0,  0, 1);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    w_valid = 0; w_ctrl = 0; w_data = 0; w_mready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_proto_err", proto_err, 0);
    rst_n = 1'b1;
    tick();

    // Table: 3-beat fill/drain, then fill-to-full with backpressure and 5th beat
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].sv, vecs[i].sc, vecs[i].sd, vecs[i].mr, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_sr);
      chk($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].e_mv);
      chk($sformatf("vec%0d_level", i), level, vecs[i].e_lvl);
      chk($sformatf("vec%0d_pkt_cnt", i), pkt_cnt, vecs[i].e_pkt);
      chk($sformatf("vec%0d_proto_err", i), proto_err, 0);
      if (vecs[i].e_mv) chk($sformatf("vec%0d_m_data", i), m_data, vecs[i].e_md);
      tick();
    end

    // Continuous streaming: 20 beats, level holds at 1, no bubbles
    for (int k = 0; k < 21; k++) begin
      if (k < 20) drive(1, 0, 32'h100 + k, 1, 0);
      else        drive(0, 0, 0, 1, 0);
      @(negedge clk);
      if (k == 0) begin
        chk("stream_first_m_valid", m_valid, 0);
        chk("stream_first_level", level, 0);
      end else begin
        chk($sformatf("stream%0d_m_valid", k), m_valid, 1);
        chk($sformatf("stream%0d_level", k), level, 1);
        chk($sformatf("stream%0d_s_ready", k), s_ready, 1);
        chk($sformatf("stream%0d_m_data", k), m_data, 32'h100 + k - 1);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stream_end_level", level, 0);
    chk("stream_end_pkt_cnt", pkt_cnt, 1);
    tick();

    // Protocol checker: fill, dropped valid, clear, changed data, set-wins
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 32'h40 + k, 0, 0);
      tick();
    end
    drive(1, 0, 32'h50, 0, 0);
    @(negedge clk);
    chk("perr_full_s_ready", s_ready, 0);
    chk("perr_full_level", level, 4);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("perr_drop_before", proto_err, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("perr_drop_set", proto_err, 1);
    tick();
    drive(1, 0, 32'h60, 0, 0);
    @(negedge clk);
    chk("perr_cleared", proto_err, 0);
    tick();
    drive(1, 0, 32'h61, 0, 0);
    @(negedge clk);
    chk("perr_change_before", proto_err, 0);
    tick();
    drive(1, 0, 32'h61, 0, 0);
    @(negedge clk);
    chk("perr_change_set", proto_err, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("perr_setwins_before", proto_err, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("perr_setwins", proto_err, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("perr_clear2", proto_err, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 0);
      @(negedge clk);
      chk($sformatf("perr_drain%0d_m_data", k), m_data, 32'h40 + k);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("perr_drain_level", level, 0);
    tick();

    // Async reset mid-stream with level=2
    drive(1, 0, 32'h70, 0, 0);
    tick();
    drive(1, 0, 32'h71, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mrst_pre_level", level, 2);
    rst_n = 1'b0;
    #1;
    chk("mrst_level", level, 0);
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_s_ready", s_ready, 1);
    chk("mrst_pkt_cnt", pkt_cnt, 0);
    #2;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("mrst_idle_m_valid", m_valid, 0);
    tick();
    drive(1, 0, 32'h77, 0, 0);
    @(negedge clk);
    chk("mrst_push_same_cycle", m_valid, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mrst_push_m_valid", m_valid, 1);
    chk("mrst_push_m_data", m_data, 32'h77);
    chk("mrst_push_level", level, 1);
    tick();

    // Packet counter wrap on the CNT_BITS=4 instance: 17 LAST beats
    for (int k = 0; k < 19; k++) begin
      w_valid = (k < 17); w_ctrl = 8'h01; w_data = k; w_mready = 1'b1;
      @(negedge clk);
      if (k == 17) chk("wrap_pkt_16pops", w_pkt, 0);
      if (k == 18) begin
        chk("wrap_pkt_17pops", w_pkt, 1);
        chk("wrap_level", w_level, 0);
      end
      tick();
    end
    w_valid = 0; w_mready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
